// File: rtl/workload_pkg.sv
// rtl/workload_pkg.sv - shared state enum and {id,size} workload struct macro for the workload scheduler
`ifndef WORKLOAD_PKG_SV
`define WORKLOAD_PKG_SV

`define WORKLOAD_S(id_w, size_w) struct packed { logic [(id_w)-1:0] id; logic [(size_w)-1:0] size; }

package workload_pkg;

    typedef enum logic [1:0] {
        eIdle  = 2'd0,
        eHold  = 2'd1,
        eDrain = 2'd2
    } state_e;

endpackage

`endif

// File: rtl/workload_rr_pick.sv
// rtl/workload_rr_pick.sv - first free unit at or after the round-robin pointer, one-hot grant
module workload_rr_pick
    import workload_pkg::*;
#(
    parameter int num_units_p = 4,
    localparam int ptr_width_lp = $clog2(num_units_p)
) (
    input  logic [num_units_p-1:0]  free,
    input  logic [ptr_width_lp-1:0] ptr,
    output logic [num_units_p-1:0]  grant,
    output logic                    any_free
);

    int idx;

    // Walk from farthest to nearest so the unit closest to ptr wins.
    always_comb begin
        grant    = '0;
        any_free = |free;
        idx      = 0;
        for (int i = num_units_p - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % num_units_p;
            if (free[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/workload_sched.sv
// rtl/workload_sched.sv - round-robin workload dispatcher with drain mode; WORKLOAD_SCHED_STATS_EN adds counters
module workload_sched
    import workload_pkg::*;
#(
    parameter int id_width_p   = 4,
    parameter int size_width_p = 8,
    parameter int num_units_p  = 4,
    localparam int width_lp    = id_width_p + size_width_p,
    localparam int ptr_width_lp = $clog2(num_units_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   v_i,
    input  logic [width_lp-1:0]    data_i,
    output logic                   ready_o,
    output logic [num_units_p-1:0] unit_v_o,
    output logic [width_lp-1:0]    unit_data_o,
    input  logic [num_units_p-1:0] unit_ready_i,
    input  logic [num_units_p-1:0] unit_done_i,
    input  logic                   drain_i,
    output logic                   drained_o,
    output logic [num_units_p-1:0] busy_o,
    output logic                   err_o
`ifdef WORKLOAD_SCHED_STATS_EN
    ,
    output logic [31:0]            dispatched_cnt_o,
    output logic [31:0]            stall_cnt_o
`endif
);

    typedef `WORKLOAD_S(id_width_p, size_width_p) workload_s;

    state_e                  state_r, state_n;
    workload_s               hold_r;
    logic [num_units_p-1:0]  busy_r, grant_r, pick_grant, grant;
    logic [ptr_width_lp-1:0] ptr_r, next_ptr;
    logic                    err_r, any_free, accept, fire;

    workload_rr_pick #(.num_units_p(num_units_p)) pick (
        .free     (~busy_r),
        .ptr      (ptr_r),
        .grant    (pick_grant),
        .any_free (any_free)
    );

    // Once a grant is locked it is never retracted; until then follow the picker.
    assign grant  = (grant_r != '0) ? grant_r : pick_grant;
    assign accept = v_i & ready_o;
    assign fire   = |(unit_v_o & unit_ready_i);

    always_comb begin
        next_ptr = ptr_r;
        for (int i = 0; i < num_units_p; i++)
            if (grant[i]) next_ptr = (i == num_units_p - 1) ? '0 : ptr_width_lp'(i + 1);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= eIdle;
            hold_r  <= '0;
            busy_r  <= '0;
            grant_r <= '0;
            ptr_r   <= '0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            busy_r  <= (busy_r & ~unit_done_i) | (fire ? grant : '0);
            if (|(unit_done_i & ~busy_r)) err_r <= 1'b1;
            if (accept) hold_r <= data_i;
            if (state_r != eHold || fire) grant_r <= '0;
            else if (grant_r == '0 && any_free) grant_r <= pick_grant;
            if (fire) ptr_r <= next_ptr;
        end
    end

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            eIdle:   if (accept) state_n = eHold;
                     else if (drain_i) state_n = eDrain;
            eHold:   if (fire) state_n = drain_i ? eDrain : eIdle;
            eDrain:  if (!drain_i) state_n = eIdle;
            default: state_n = eIdle;
        endcase
    end

    always_comb begin
        ready_o   = 1'b0;
        unit_v_o  = '0;
        drained_o = 1'b0;
        if (!reset_i) begin
            unique case (state_r)
                eIdle:   ready_o   = ~drain_i;
                eHold:   unit_v_o  = grant;
                eDrain:  drained_o = drain_i && (busy_r == '0);
                default: ;
            endcase
        end
    end

    assign unit_data_o = hold_r;
    assign busy_o      = busy_r;
    assign err_o       = err_r;

`ifdef WORKLOAD_SCHED_STATS_EN
    logic [31:0] dispatched_cnt_r, stall_cnt_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dispatched_cnt_r <= '0;
            stall_cnt_r      <= '0;
        end else begin
            if (fire && dispatched_cnt_r != '1) dispatched_cnt_r <= dispatched_cnt_r + 32'd1;
            if (state_r == eHold && !any_free && stall_cnt_r != '1) stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end

    assign dispatched_cnt_o = dispatched_cnt_r;
    assign stall_cnt_o      = stall_cnt_r;
`endif

endmodule

// File: tb/tb_workload_sched.sv
// tb/tb_workload_sched.sv - scoreboard bench for workload_sched (4 units, 4-bit id, 8-bit size)
module tb_workload_sched;

    localparam int NU = 4;
    localparam int W  = 12;

    logic          clk = 1'b0;
    logic          reset_i, v_i, drain_i, ready_o, drained_o, err_o;
    logic [W-1:0]  data_i, unit_data_o;
    logic [NU-1:0] unit_v_o, unit_ready_i, unit_done_i, busy_o;
`ifdef WORKLOAD_SCHED_STATS_EN
    logic [31:0]   dispatched_cnt_o, stall_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [NU-1:0] unit;
        logic [W-1:0]  data;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    workload_sched #(.id_width_p(4), .size_width_p(8), .num_units_p(NU)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .v_i          (v_i),
        .data_i       (data_i),
        .ready_o      (ready_o),
        .unit_v_o     (unit_v_o),
        .unit_data_o  (unit_data_o),
        .unit_ready_i (unit_ready_i),
        .unit_done_i  (unit_done_i),
        .drain_i      (drain_i),
        .drained_o    (drained_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
`ifdef WORKLOAD_SCHED_STATS_EN
        ,
        .dispatched_cnt_o (dispatched_cnt_o),
        .stall_cnt_o      (stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change only at negedge; handshakes are judged 1ns before the posedge.
    always begin
        @(negedge clk);
        #4;
        if (!reset_i && (unit_v_o & unit_ready_i) != '0) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL dispatch_unexpected unit_v=%b data=%h required=no dispatch", unit_v_o, unit_data_o);
            end else begin
                mon_e = sb.pop_front();
                if (unit_v_o !== mon_e.unit || unit_data_o !== mon_e.data) begin
                    failures++;
                    $display("FAIL dispatch unit_v=%b data=%h required unit_v=%b data=%h",
                             unit_v_o, unit_data_o, mon_e.unit, mon_e.data);
                end
            end
        end
    end

    function automatic logic [W-1:0] wl(input int id);
        logic [7:0] sz;
        sz = 8'(id * 37 + 5);
        return {id[3:0], sz};
    endfunction

    task automatic send(input int id, input logic [NU-1:0] unit);
        int n;
        exp_t e;
        n = 0;
        #1;
        while (ready_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL send_timeout id=%0d ready=%b required=1", id, ready_o);
        end else begin
            v_i    = 1'b1;
            data_i = wl(id);
            e.unit = unit;
            e.data = wl(id);
            sb.push_back(e);
        end
        @(negedge clk);
        v_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL dispatch_timeout pending=%0d required=0", sb.size());
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1; v_i = 1'b0; drain_i = 1'b0; data_i = '0;
        unit_ready_i = '1; unit_done_i = '0;
        @(negedge clk); #1;
        checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b required=0", ready_o); end
        checks++; if (unit_v_o !== 4'b0) begin failures++; $display("FAIL rst_unit_v got=%b required=0000", unit_v_o); end
        checks++; if (drained_o !== 1'b0) begin failures++; $display("FAIL rst_drained got=%b required=0", drained_o); end
        @(negedge clk); reset_i = 1'b0; #1;
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL post_rst_ready got=%b required=1", ready_o); end
        checks++; if (busy_o !== 4'b0) begin failures++; $display("FAIL post_rst_busy got=%b required=0000", busy_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL post_rst_err got=%b required=0", err_o); end
    endtask

    task automatic test_fill();
        @(negedge clk);
        for (int i = 0; i < 4; i++) send(i, 4'(1 << i));
        wait_idle();
        #1;
        checks++; if (busy_o !== 4'b1111) begin failures++; $display("FAIL fill_busy got=%b required=1111", busy_o); end
    endtask

    task automatic test_stall();
        @(negedge clk);
        send(4, 4'b0100);
        repeat (2) begin
            #1;
            checks++; if (unit_v_o !== 4'b0) begin failures++; $display("FAIL stall_unit_v got=%b required=0000", unit_v_o); end
            @(negedge clk);
        end
        unit_done_i = 4'b0100; #1;
        checks++; if (unit_v_o !== 4'b0) begin failures++; $display("FAIL stall_done_cycle got=%b required=0000", unit_v_o); end
        @(negedge clk); unit_done_i = '0; #1;
        checks++; if (unit_v_o !== 4'b0100) begin failures++; $display("FAIL stall_regrant got=%b required=0100", unit_v_o); end
        wait_idle();
        #1;
        checks++; if (busy_o !== 4'b1111) begin failures++; $display("FAIL stall_busy got=%b required=1111", busy_o); end
    endtask

    task automatic test_ready_hold();
        @(negedge clk); unit_ready_i = 4'b1110; unit_done_i = 4'b0001;
        @(negedge clk); unit_done_i = '0;
        send(5, 4'b0001);
        repeat (5) begin
            #1;
            checks++;
            if (unit_v_o !== 4'b0001 || unit_data_o !== wl(5)) begin
                failures++;
                $display("FAIL hold_stable unit_v=%b data=%h required unit_v=0001 data=%h", unit_v_o, unit_data_o, wl(5));
            end
            @(negedge clk);
        end
        unit_ready_i = '1;
        @(negedge clk); #1;
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL hold_release pending=%0d required=0", sb.size()); end
        checks++; if (busy_o !== 4'b1111) begin failures++; $display("FAIL hold_busy got=%b required=1111", busy_o); end
    endtask

    task automatic test_err();
        @(negedge clk); unit_done_i = 4'b1000;
        @(negedge clk); unit_done_i = '0; #1;
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL err_legal_done got=%b required=0", err_o); end
        @(negedge clk); unit_done_i = 4'b1000;
        @(negedge clk); unit_done_i = '0; #1;
        checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL err_set got=%b required=1", err_o); end
        checks++; if (busy_o !== 4'b0111) begin failures++; $display("FAIL err_busy got=%b required=0111", busy_o); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b required=1", err_o); end
    endtask

    task automatic test_drain();
        @(negedge clk); unit_done_i = 4'b0001;
        @(negedge clk); unit_done_i = '0; drain_i = 1'b1; #1;
        checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL drain_ready got=%b required=0", ready_o); end
        @(negedge clk); unit_done_i = 4'b0110; #1;
        checks++; if (drained_o !== 1'b0) begin failures++; $display("FAIL drain_busy got=%b required=0", drained_o); end
        @(negedge clk); unit_done_i = '0; #1;
        checks++; if (drained_o !== 1'b1) begin failures++; $display("FAIL drain_done got=%b required=1", drained_o); end
        drain_i = 1'b0;
        @(negedge clk); #1;
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL drain_exit_ready got=%b required=1", ready_o); end
    endtask

    task automatic test_drain_in_hold();
        @(negedge clk); unit_ready_i = '0;
        send(6, 4'b0010);
        drain_i = 1'b1; #1;
        checks++; if (unit_v_o !== 4'b0010) begin failures++; $display("FAIL dh_grant got=%b required=0010", unit_v_o); end
        @(negedge clk); unit_ready_i = '1;
        @(negedge clk); #1;
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL dh_dispatch pending=%0d required=0", sb.size()); end
        checks++; if (drained_o !== 1'b0 || ready_o !== 1'b0) begin failures++; $display("FAIL dh_state drained=%b ready=%b required 0 0", drained_o, ready_o); end
        @(negedge clk); unit_done_i = 4'b0010;
        @(negedge clk); unit_done_i = '0; #1;
        checks++; if (drained_o !== 1'b1) begin failures++; $display("FAIL dh_drained got=%b required=1", drained_o); end
        drain_i = 1'b0;
        @(negedge clk); #1;
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL dh_exit_ready got=%b required=1", ready_o); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        send(7, 4'b0100);
        wait_idle();
        @(negedge clk); unit_ready_i = '0;
        send(8, 4'b1000);
        #1;
        checks++; if (unit_v_o !== 4'b1000) begin failures++; $display("FAIL rm_grant got=%b required=1000", unit_v_o); end
        @(negedge clk); reset_i = 1'b1; #1;
        checks++; if (unit_v_o !== 4'b0 || ready_o !== 1'b0) begin failures++; $display("FAIL rm_in_reset unit_v=%b ready=%b required 0000 0", unit_v_o, ready_o); end
        sb.delete();
        @(negedge clk); reset_i = 1'b0; unit_ready_i = '1; #1;
        checks++; if (busy_o !== 4'b0) begin failures++; $display("FAIL rm_busy got=%b required=0000", busy_o); end
        checks++; if (unit_v_o !== 4'b0) begin failures++; $display("FAIL rm_unit_v got=%b required=0000", unit_v_o); end
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL rm_ready got=%b required=1", ready_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL rm_err got=%b required=0", err_o); end
        send(9, 4'b0001);
        wait_idle();
        #1;
        checks++; if (busy_o !== 4'b0001) begin failures++; $display("FAIL rm_restart_busy got=%b required=0001", busy_o); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t required=finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_stall();
        test_ready_hold();
        test_err();
        test_drain();
        test_drain_in_hold();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
